// File: rtl/conv_pkg.sv
// Shared defaults, sample type and streamer state encoding for the conv layer pipeline.
package conv_pkg;

   localparam int unsigned DATA_WIDTH      = 16;
   localparam int unsigned FRACTIONAL_BITS = 8;

   typedef logic signed [DATA_WIDTH-1:0] sample_t;

   typedef enum logic [1:0] {IDLE, ARM, STREAM} streamer_state_t;

   // Index width for a count of n items, never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/conv_act_streamer_if.sv
// Upstream result capture, status and downstream element stream of conv_act_streamer.
interface conv_act_streamer_if #(
   parameter int unsigned DATA_WIDTH   = conv_pkg::DATA_WIDTH,
   parameter int unsigned NUM_CHANNELS = 1,
   parameter int unsigned NUM_FRAMES   = 4
);

   localparam int unsigned CH_W = conv_pkg::idx_width(NUM_CHANNELS);
   localparam int unsigned FR_W = conv_pkg::idx_width(NUM_FRAMES);

   logic                         i_done_tick;
   logic signed [DATA_WIDTH-1:0] i_result [NUM_CHANNELS][NUM_FRAMES];
   logic                         o_busy;
   logic                         o_overrun;
   logic                         o_valid;
   logic                         i_ready;
   logic signed [DATA_WIDTH-1:0] o_data;
   logic [CH_W-1:0]              o_channel;
   logic [FR_W-1:0]              o_frame;
   logic                         o_last;

   modport master (
      input  i_done_tick, i_result, i_ready,
      output o_busy, o_overrun, o_valid, o_data, o_channel, o_frame, o_last
   );

   modport slave (
      output i_done_tick, i_result, i_ready,
      input  o_busy, o_overrun, o_valid, o_data, o_channel, o_frame, o_last
   );

endinterface

// File: rtl/conv_act_unit.sv
// Single-element activation: ReLU by default, leaky ReLU when CONV_ACT_LEAKY_EN is defined.
module conv_act_unit #(
   parameter int unsigned DATA_WIDTH = conv_pkg::DATA_WIDTH,
   parameter int unsigned LEAK_SHIFT = 3
) (
   input  logic signed [DATA_WIDTH-1:0] x,
   output logic signed [DATA_WIDTH-1:0] y
);

`ifdef CONV_ACT_LEAKY_EN
   // Arithmetic shift floors toward minus infinity, so -1 stays -1.
   always_comb begin
      y = x;
      if (x[DATA_WIDTH-1]) begin
         y = x >>> LEAK_SHIFT;
      end
   end
`else
   logic unused_leak_shift;
   assign unused_leak_shift = ^LEAK_SHIFT;

   always_comb begin
      y = x;
      if (x[DATA_WIDTH-1]) begin
         y = '0;
      end
   end
`endif

endmodule

// File: rtl/conv_act_streamer.sv
// Captures the conv result array through the activation and streams it frame-major.
// Build option: CONV_ACT_LEAKY_EN selects leaky ReLU (inside conv_act_unit).
module conv_act_streamer
   import conv_pkg::*;
#(
   parameter int unsigned DATA_WIDTH      = conv_pkg::DATA_WIDTH,
   parameter int unsigned FRACTIONAL_BITS = conv_pkg::FRACTIONAL_BITS,
   parameter int unsigned NUM_CHANNELS    = 1,
   parameter int unsigned NUM_FRAMES      = 4,
   parameter int unsigned LEAK_SHIFT      = 3
) (
   input logic                 clk,
   input logic                 rst_n,
   conv_act_streamer_if.master bus
);

   localparam int unsigned TOTAL = NUM_CHANNELS * NUM_FRAMES;
   localparam int unsigned CH_W  = idx_width(NUM_CHANNELS);
   localparam int unsigned FR_W  = idx_width(NUM_FRAMES);
   localparam int unsigned IDX_W = idx_width(TOTAL);

   localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CHANNELS - 1);
   localparam logic [FR_W-1:0]  FR_LAST  = FR_W'(NUM_FRAMES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TOTAL - 1);

   streamer_state_t state_q, state_d;

   logic signed [DATA_WIDTH-1:0] act   [TOTAL];
   logic signed [DATA_WIDTH-1:0] res_q [TOTAL];
   logic [IDX_W-1:0]             idx_q, idx_d;
   logic [CH_W-1:0]              ch_q, ch_d;
   logic [FR_W-1:0]              fr_q, fr_d;
   logic                         overrun_q, overrun_d;
   logic                         last_elem, handshake, last_hs;

   logic unused_frac_bits;
   assign unused_frac_bits = ^FRACTIONAL_BITS;

   // Buffer is stored in stream order: element f*NUM_CHANNELS + c.
   for (genvar c = 0; c < int'(NUM_CHANNELS); c++) begin : g_ch
      for (genvar f = 0; f < int'(NUM_FRAMES); f++) begin : g_fr
         conv_act_unit #(
            .DATA_WIDTH (DATA_WIDTH),
            .LEAK_SHIFT (LEAK_SHIFT)
         ) u_act (
            .x (bus.i_result[c][f]),
            .y (act[f * int'(NUM_CHANNELS) + c])
         );
      end
   end

   assign last_elem = (idx_q == IDX_LAST);
   assign handshake = (state_q == STREAM) && bus.i_ready;
   assign last_hs   = handshake && last_elem;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.i_done_tick) state_d = ARM;
         ARM:     state_d = STREAM;
         STREAM:  if (last_hs) state_d = bus.i_done_tick ? ARM : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A done tick is only accepted from IDLE or on the final handshake edge.
   assign overrun_d = bus.i_done_tick &&
                      ((state_q == ARM) || ((state_q == STREAM) && !last_hs));

   always_comb begin
      idx_d = idx_q;
      ch_d  = ch_q;
      fr_d  = fr_q;
      if (state_q == ARM) begin
         idx_d = '0;
         ch_d  = '0;
         fr_d  = '0;
      end else if (handshake) begin
         idx_d = last_elem ? '0 : idx_q + 1'b1;
         if (ch_q == CH_LAST) begin
            ch_d = '0;
            fr_d = (fr_q == FR_LAST) ? '0 : fr_q + 1'b1;
         end else begin
            ch_d = ch_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q     <= '{default: '0};
         idx_q     <= '0;
         ch_q      <= '0;
         fr_q      <= '0;
         overrun_q <= 1'b0;
      end else begin
         if (state_q == ARM) begin
            res_q <= act;
         end
         idx_q     <= idx_d;
         ch_q      <= ch_d;
         fr_q      <= fr_d;
         overrun_q <= overrun_d;
      end
   end

   always_comb begin
      bus.o_busy    = (state_q != IDLE);
      bus.o_valid   = (state_q == STREAM);
      bus.o_overrun = overrun_q;
      bus.o_channel = ch_q;
      bus.o_frame   = fr_q;
      bus.o_data    = '0;
      bus.o_last    = 1'b0;
      if (state_q == STREAM) begin
         bus.o_data = res_q[idx_q];
         bus.o_last = last_elem;
      end
   end

endmodule
